// File: rtl/bru_resolve.sv
// bru_resolve: one-stage pipelined branch resolution unit.
//
// A branch op is captured into a single output register. The register holds
// the resolved condition, the branch target, the link PC and a cancel flag.
// The cancel flag is raised when the resolved next PC differs from the fetch
// prediction. An optional branch history table of 2-bit counters trains on
// resolved conditional branches and serves combinational fetch lookups.
//
// Optional feature macro: LSOC1K_BRU_BHT_EN (BHT present when defined).
//
// Parameters:
//   GRLEN      datapath width, 32 or 64
//   BHT_DEPTH  BHT entries, power of two 4..1024 (only with LSOC1K_BRU_BHT_EN)
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (branch op presented / accepted)
//   branch_op             LSOC1K_BRU_* op code
//   branch_a, branch_b    operands
//   branch_pc             PC of the branch
//   branch_offset         sign-extended offset
//   pred_taken            fetch-stage predicted direction
//   pred_target           fetch-stage predicted target
//   flush                 drop the held result and block capture this cycle
//   out_valid / out_ready output handshake
//   bru_taken, bru_cancel, bru_wen, bru_target, bru_link_pc, bru_pc
//                         registered results
//   fetch_pc              BHT lookup address
//   fetch_pred_taken      BHT prediction for fetch_pc (combinational)
//   mispredict_cnt        saturating count of accepted cancels
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. in_ready = !out_valid || out_ready, so a new op may be captured in
// the same cycle the held result is consumed. While out_valid && !out_ready,
// every output holds stable. A cycle with flush high performs no capture and
// no accepted output transfer; the held entry is discarded.

`ifndef LSOC1K_BRU_CODE_BIT
`define LSOC1K_BRU_CODE_BIT 4
`endif
`ifndef LSOC1K_BRU_EQZ
`define LSOC1K_BRU_EQZ 4'd0
`define LSOC1K_BRU_NEZ 4'd1
`define LSOC1K_BRU_EQ  4'd2
`define LSOC1K_BRU_NE  4'd3
`define LSOC1K_BRU_LT  4'd4
`define LSOC1K_BRU_GE  4'd5
`define LSOC1K_BRU_LTU 4'd6
`define LSOC1K_BRU_GEU 4'd7
`define LSOC1K_BRU_JR  4'd8
`define LSOC1K_BRU_BL  4'd9
`endif

module bru_resolve #(
  parameter int GRLEN     = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [`LSOC1K_BRU_CODE_BIT-1:0] branch_op,
  input  logic [GRLEN-1:0]                branch_a,
  input  logic [GRLEN-1:0]                branch_b,
  input  logic [GRLEN-1:0]                branch_pc,
  input  logic [GRLEN-1:0]                branch_offset,
  input  logic                            pred_taken,
  input  logic [GRLEN-1:0]                pred_target,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            bru_taken,
  output logic                            bru_cancel,
  output logic                            bru_wen,
  output logic [GRLEN-1:0]                bru_target,
  output logic [GRLEN-1:0]                bru_link_pc,
  output logic [GRLEN-1:0]                bru_pc,
  input  logic [GRLEN-1:0]                fetch_pc,
  output logic                            fetch_pred_taken,
  output logic [31:0]                     mispredict_cnt
);

  // ---------------- combinational resolution ----------------
  logic [GRLEN-3:0] pc_word;
  logic [GRLEN-3:0] pc_word_inc;
  logic [GRLEN-1:0] next_pc;
  logic [GRLEN-1:0] true_pc;
  logic [GRLEN-1:0] jr_pc;
  logic [GRLEN-1:0] target;
  logic [GRLEN-1:0] pred_next;
  logic             taken;
  logic             is_link;
  logic             is_cond;
  logic             is_jr;
  logic             cancel;

  assign pc_word     = branch_pc[GRLEN-1:2];
  assign pc_word_inc = pc_word + {{(GRLEN-3){1'b0}}, 1'b1};
  assign next_pc     = {pc_word_inc, 2'b00};
  // Branch targets are relative to the word-aligned PC; JR keeps low bits.
  assign true_pc     = {pc_word, 2'b00} + branch_offset;
  assign jr_pc       = branch_a + branch_offset;

  always_comb begin
    taken   = 1'b0;
    is_link = 1'b0;
    is_cond = 1'b0;
    is_jr   = 1'b0;
    case (branch_op)
      `LSOC1K_BRU_EQZ: begin is_cond = 1'b1; taken = (branch_a == '0); end
      `LSOC1K_BRU_NEZ: begin is_cond = 1'b1; taken = (branch_a != '0); end
      `LSOC1K_BRU_EQ:  begin is_cond = 1'b1; taken = (branch_a == branch_b); end
      `LSOC1K_BRU_NE:  begin is_cond = 1'b1; taken = (branch_a != branch_b); end
      `LSOC1K_BRU_LT:  begin is_cond = 1'b1; taken = ($signed(branch_a) <  $signed(branch_b)); end
      `LSOC1K_BRU_GE:  begin is_cond = 1'b1; taken = ($signed(branch_a) >= $signed(branch_b)); end
      `LSOC1K_BRU_LTU: begin is_cond = 1'b1; taken = (branch_a <  branch_b); end
      `LSOC1K_BRU_GEU: begin is_cond = 1'b1; taken = (branch_a >= branch_b); end
      `LSOC1K_BRU_JR:  begin is_link = 1'b1; is_jr = 1'b1; taken = 1'b1; end
      `LSOC1K_BRU_BL:  begin is_link = 1'b1; taken = 1'b1; end
      default: ; // unknown op: not taken, no link write
    endcase
  end

  assign target    = is_jr ? jr_pc : (taken ? true_pc : next_pc);
  assign pred_next = pred_taken ? pred_target : next_pc;
  assign cancel    = (target != pred_next);

  // ---------------- handshake and result register ----------------
  logic capture;
  logic out_fire;
  logic held_cond;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign out_fire = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      bru_taken      <= 1'b0;
      bru_cancel     <= 1'b0;
      bru_wen        <= 1'b0;
      bru_target     <= '0;
      bru_link_pc    <= '0;
      bru_pc         <= '0;
      held_cond      <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      if (flush)         out_valid <= 1'b0;
      else if (capture)  out_valid <= 1'b1;
      else if (out_fire) out_valid <= 1'b0;

      if (capture) begin
        bru_taken   <= taken;
        bru_cancel  <= cancel;
        bru_wen     <= is_link;
        bru_target  <= target;
        bru_link_pc <= next_pc;
        bru_pc      <= branch_pc;
        held_cond   <= is_cond;
      end

      if (out_fire && bru_cancel && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  // ---------------- branch history table ----------------
`ifdef LSOC1K_BRU_BHT_EN
  localparam int IDX = $clog2(BHT_DEPTH);

  logic [1:0]     bht [BHT_DEPTH];
  logic [IDX-1:0] upd_idx;
  logic [IDX-1:0] look_idx;
  logic           unused_fetch_bits;

  assign upd_idx           = bru_pc[IDX+1:2];
  assign look_idx          = fetch_pc[IDX+1:2];
  assign unused_fetch_bits = ^{fetch_pc[GRLEN-1:IDX+2], fetch_pc[1:0]};

  // Trains on the held entry when it is consumed; a same-cycle lookup reads
  // the pre-update counter because the array is read combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (out_fire && held_cond) begin
      if (bru_taken && (bht[upd_idx] != 2'b11))
        bht[upd_idx] <= bht[upd_idx] + 2'd1;
      else if (!bru_taken && (bht[upd_idx] != 2'b00))
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
    end
  end

  assign fetch_pred_taken = bht[look_idx][1];
`else
  logic unused_bht_inputs;

  assign unused_bht_inputs = ^{fetch_pc, held_cond, (BHT_DEPTH > 0)};
  assign fetch_pred_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_bru_resolve.sv
module tb_bru_resolve;

  localparam logic [3:0] OP_EQZ = 4'd0;
  localparam logic [3:0] OP_NE  = 4'd3;
  localparam logic [3:0] OP_EQ  = 4'd2;
  localparam logic [3:0] OP_LT  = 4'd4;
  localparam logic [3:0] OP_GE  = 4'd5;
  localparam logic [3:0] OP_LTU = 4'd6;
  localparam logic [3:0] OP_GEU = 4'd7;
  localparam logic [3:0] OP_JR  = 4'd8;
  localparam logic [3:0] OP_BL  = 4'd9;
  localparam logic [3:0] OP_BAD = 4'd15;

`ifdef LSOC1K_BRU_BHT_EN
  localparam logic BHT_ON = 1'b1;
`else
  localparam logic BHT_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- 32-bit DUT (BHT_DEPTH=4) ----------------
  logic        in_valid, in_ready, pred_taken, flush, out_valid, out_ready;
  logic [3:0]  branch_op;
  logic [31:0] branch_a, branch_b, branch_pc, branch_offset, pred_target;
  logic        bru_taken, bru_cancel, bru_wen, fetch_pred_taken;
  logic [31:0] bru_target, bru_link_pc, bru_pc, fetch_pc, mispredict_cnt;

  bru_resolve #(.GRLEN(32), .BHT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .branch_op(branch_op), .branch_a(branch_a), .branch_b(branch_b),
    .branch_pc(branch_pc), .branch_offset(branch_offset),
    .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .bru_taken(bru_taken),
    .bru_cancel(bru_cancel), .bru_wen(bru_wen), .bru_target(bru_target),
    .bru_link_pc(bru_link_pc), .bru_pc(bru_pc), .fetch_pc(fetch_pc),
    .fetch_pred_taken(fetch_pred_taken), .mispredict_cnt(mispredict_cnt)
  );

  // ---------------- 64-bit DUT ----------------
  logic        y_in_valid, y_in_ready, y_pt, y_flush, y_out_valid, y_out_ready;
  logic [3:0]  y_op;
  logic [63:0] y_a, y_b, y_pc, y_off, y_ptgt;
  logic        y_taken, y_cancel, y_wen, y_fetch_pred;
  logic [63:0] y_target, y_link, y_bpc, y_fetch_pc;
  logic [31:0] y_cnt;

  bru_resolve #(.GRLEN(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(y_in_valid), .in_ready(y_in_ready),
    .branch_op(y_op), .branch_a(y_a), .branch_b(y_b),
    .branch_pc(y_pc), .branch_offset(y_off),
    .pred_taken(y_pt), .pred_target(y_ptgt), .flush(y_flush),
    .out_valid(y_out_valid), .out_ready(y_out_ready), .bru_taken(y_taken),
    .bru_cancel(y_cancel), .bru_wen(y_wen), .bru_target(y_target),
    .bru_link_pc(y_link), .bru_pc(y_bpc), .fetch_pc(y_fetch_pc),
    .fetch_pred_taken(y_fetch_pred), .mispredict_cnt(y_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off,
                        input logic pt, input logic [31:0] ptgt);
    branch_op = op; branch_a = a; branch_b = b; branch_pc = pc;
    branch_offset = off; pred_taken = pt; pred_target = ptgt;
  endtask

  task automatic exec_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] off,
                         input logic pt, input logic [31:0] ptgt);
    set_op(op, a, b, pc, off, pt, ptgt);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic tk, input logic [31:0] tgt,
                           input logic cn, input logic wn, input logic [31:0] lnk);
    check({tag, ".valid"},  {63'd0, out_valid},  64'd1);
    check({tag, ".taken"},  {63'd0, bru_taken},  {63'd0, tk});
    check({tag, ".target"}, {32'd0, bru_target}, {32'd0, tgt});
    check({tag, ".cancel"}, {63'd0, bru_cancel}, {63'd0, cn});
    check({tag, ".wen"},    {63'd0, bru_wen},    {63'd0, wn});
    check({tag, ".link"},   {32'd0, bru_link_pc}, {32'd0, lnk});
  endtask

  task automatic y_exec(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] pc, input logic [63:0] off,
                        input logic pt, input logic [63:0] ptgt);
    y_op = op; y_a = a; y_b = b; y_pc = pc; y_off = off; y_pt = pt; y_ptgt = ptgt;
    y_in_valid = 1'b1;
    step();
    y_in_valid = 1'b0;
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
    fetch_pc = pc;
    #1;
    check(tag, {63'd0, fetch_pred_taken}, {63'd0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    set_op(OP_BAD, 0, 0, 0, 0, 1'b0, 0);
    fetch_pc = 32'h10;
    y_in_valid = 1'b0; y_out_ready = 1'b1; y_flush = 1'b0; y_fetch_pc = '0;
    y_op = OP_BAD; y_a = '0; y_b = '0; y_pc = '0; y_off = '0; y_pt = 1'b0; y_ptgt = '0;
    step();
    step();

    // Reset state
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.in_ready",  {63'd0, in_ready},  64'd1);
    check("rst.taken",     {63'd0, bru_taken}, 64'd0);
    check("rst.cancel",    {63'd0, bru_cancel}, 64'd0);
    check("rst.wen",       {63'd0, bru_wen},   64'd0);
    check("rst.target",    {32'd0, bru_target}, 64'd0);
    check("rst.link",      {32'd0, bru_link_pc}, 64'd0);
    check("rst.pc",        {32'd0, bru_pc},    64'd0);
    check("rst.cnt",       {32'd0, mispredict_cnt}, 64'd0);
    check_pred("rst.fetch_pred", 32'h10, 1'b0);
    reset = 1'b0;

    // BLT signed: -1 < 1 taken, predicted not-taken -> cancel
    exec_op(OP_LT, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h20, 1'b0, 32'h0);
    check_res("blt", 1'b1, 32'h1020, 1'b1, 1'b0, 32'h1004);
    check("blt.pc", {32'd0, bru_pc}, 64'h1000);
    check("blt.cnt_before", {32'd0, mispredict_cnt}, 64'd0);
    drain();
    check("blt.valid_after", {63'd0, out_valid}, 64'd0);
    check("blt.cnt_after", {32'd0, mispredict_cnt}, 64'd1);

    // JR keeps unaligned target bits; correct prediction
    exec_op(OP_JR, 32'h2003, 32'h0, 32'h3000, 32'h4, 1'b1, 32'h2007);
    check_res("jr", 1'b1, 32'h2007, 1'b0, 1'b1, 32'h3004);
    drain();

    // BL with negative offset
    exec_op(OP_BL, 32'h0, 32'h0, 32'h4000, 32'hFFFF_FFF0, 1'b1, 32'h3FF0);
    check_res("bl", 1'b1, 32'h3FF0, 1'b0, 1'b1, 32'h4004);
    drain();

    // BNE on equal operands, predicted taken -> cancel
    exec_op(OP_NE, 32'd5, 32'd5, 32'h500, 32'h40, 1'b1, 32'h540);
    check_res("bne", 1'b0, 32'h504, 1'b1, 1'b0, 32'h504);
    drain();

    // BGE signed 1 >= -1 taken; BGEU 1 >= 0xFFFFFFFF not taken
    exec_op(OP_GE, 32'd1, 32'hFFFF_FFFF, 32'h700, 32'h10, 1'b1, 32'h710);
    check_res("bge", 1'b1, 32'h710, 1'b0, 1'b0, 32'h704);
    drain();
    exec_op(OP_GEU, 32'd1, 32'hFFFF_FFFF, 32'h700, 32'h10, 1'b0, 32'h0);
    check_res("bgeu", 1'b0, 32'h704, 1'b0, 1'b0, 32'h704);
    drain();

    // BEQ at unaligned pc: target from aligned pc, wrong predicted target
    exec_op(OP_EQ, 32'd9, 32'd9, 32'h1006, 32'h10, 1'b1, 32'h1000);
    check_res("beq_unal", 1'b1, 32'h1014, 1'b1, 1'b0, 32'h1008);
    drain();
    check("beq_unal.cnt", {32'd0, mispredict_cnt}, 64'd3);

    // Unknown op: not taken, no link write
    exec_op(OP_BAD, 32'd0, 32'd0, 32'h602, 32'h100, 1'b0, 32'h0);
    check_res("bad_op", 1'b0, 32'h604, 1'b0, 1'b0, 32'h604);
    drain();

    // 64-bit datapath checks
    y_exec(OP_LTU, 64'hFFFF_FFFF_0000_0000, 64'd1, 64'h8000, 64'h100, 1'b0, 64'h0);
    check("y_ltu.valid",  {63'd0, y_out_valid}, 64'd1);
    check("y_ltu.taken",  {63'd0, y_taken}, 64'd0);
    check("y_ltu.target", y_target, 64'h8004);
    y_exec(OP_EQZ, 64'h1_0000_0000, 64'd0, 64'h9000, 64'h40, 1'b1, 64'h9040);
    check("y_eqz.taken",  {63'd0, y_taken}, 64'd0);
    check("y_eqz.target", y_target, 64'h9004);
    check("y_eqz.cancel", {63'd0, y_cancel}, 64'd1);
    y_exec(OP_LT, 64'h8000_0000_0000_0000, 64'd1, 64'hA000, 64'h80, 1'b1, 64'hA080);
    check("y_lt.taken",   {63'd0, y_taken}, 64'd1);
    check("y_lt.target",  y_target, 64'hA080);
    step();
    check("y.cnt", {32'd0, y_cnt}, 64'd1);

    // Backpressure: in_valid held, out_ready low for 3 cycles
    set_op(OP_EQZ, 32'd0, 32'd0, 32'h900, 32'h10, 1'b1, 32'h910);
    in_valid = 1'b1;
    step();
    set_op(OP_EQZ, 32'd0, 32'd0, 32'hA00, 32'h10, 1'b1, 32'hA10);
    for (int i = 0; i < 3; i++) begin
      check("bp.in_ready", {63'd0, in_ready}, 64'd0);
      check("bp.valid",    {63'd0, out_valid}, 64'd1);
      check("bp.target",   {32'd0, bru_target}, 64'h910);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_released", {63'd0, in_ready}, 64'd1);
    step();
    check("b2b.first",  {32'd0, bru_target}, 64'hA10);
    check("b2b.valid1", {63'd0, out_valid}, 64'd1);
    set_op(OP_EQZ, 32'd0, 32'd0, 32'hB00, 32'h10, 1'b1, 32'hB10);
    step();
    check("b2b.second", {32'd0, bru_target}, 64'hB10);
    check("b2b.valid2", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    step();
    check("b2b.drained", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
    check("b2b.cnt", {32'd0, mispredict_cnt}, 64'd3);

    // Asynchronous reset while a result is held
    exec_op(OP_LT, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h20, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    check("arst.valid",  {63'd0, out_valid}, 64'd0);
    check("arst.taken",  {63'd0, bru_taken}, 64'd0);
    check("arst.cancel", {63'd0, bru_cancel}, 64'd0);
    check("arst.target", {32'd0, bru_target}, 64'd0);
    check("arst.link",   {32'd0, bru_link_pc}, 64'd0);
    check("arst.pc",     {32'd0, bru_pc}, 64'd0);
    check("arst.cnt",    {32'd0, mispredict_cnt}, 64'd0);
    check("arst.in_ready", {63'd0, in_ready}, 64'd1);
    step();
    reset = 1'b0;

    // Flush a taken, mispredicted branch; capture blocked in the flush cycle
    exec_op(OP_EQ, 32'd3, 32'd3, 32'h10, 32'h40, 1'b0, 32'h0);
    check("fl.pre_cancel", {63'd0, bru_cancel}, 64'd1);
    set_op(OP_EQ, 32'd3, 32'd3, 32'h20, 32'h40, 1'b0, 32'h0);
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl.valid", {63'd0, out_valid}, 64'd0);
    check("fl.no_capture", {32'd0, bru_pc}, 64'h10);
    check("fl.cnt", {32'd0, mispredict_cnt}, 64'd0);
    check_pred("fl.bht", 32'h10, 1'b0);

    // BHT training: four taken BEQ at pc 0x10 back to back
    set_op(OP_EQ, 32'd7, 32'd7, 32'h10, 32'h8, 1'b1, 32'h18);
    fetch_pc = 32'h10;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    check_pred("bht.t0", 32'h10, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      check_pred("bht.taken", 32'h10, BHT_ON);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check_pred("bht.sat", 32'h10, BHT_ON);
    check_pred("bht.alias", 32'h20, BHT_ON);
    check_pred("bht.other_idx", 32'h14, 1'b0);

    // Two not-taken branches: 11 -> 10 -> 01
    exec_op(OP_EQ, 32'd7, 32'd8, 32'h10, 32'h8, 1'b0, 32'h0);
    check_res("bht.nt", 1'b0, 32'h14, 1'b0, 1'b0, 32'h14);
    drain();
    check_pred("bht.nt1", 32'h10, BHT_ON);
    exec_op(OP_EQ, 32'd7, 32'd8, 32'h10, 32'h8, 1'b0, 32'h0);
    drain();
    check_pred("bht.nt2", 32'h10, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
